cvxif_copro_responder: RTL and testbench
========================================

// Module: cvxif_copro_responder
// PURPOSE
// - Coprocessor-side end of the CV-X-IF port that the core drives when CVA6ConfigCvxifEn=1.
// - Decodes offered custom-0 instructions and accepts or rejects them.
// - Buffers accepted instructions until the core commits or kills them.
// - Executes committed instructions in order with fixed latency and returns results through a valid/ready result channel.
// PARAMETERS
// XLEN     64  operand/result width (matches CVA6ConfigXlen)
// ID_W     3   instruction id width
// DEPTH    4   in-flight instruction buffer entries (power of 2, >=2)
// LATENCY  2   execute cycles per instruction (>=1)
// PORTS
// clk_i                    in   1       clock
// rst_ni                   in   1       synchronous reset, active low
// x_issue_valid_i          in   1       core offers instruction
// x_issue_ready_o          out  1       responder can take an offer
// x_issue_instr_i          in   32      offered instruction word
// x_issue_id_i             in   ID_W    offered instruction id
// x_issue_rs1_i/rs2_i      in   XLEN    source operands, valid with the offer
// x_issue_accept_o         out  1       offer decoded as ours (qualified by handshake)
// x_issue_writeback_o      out  1       accepted instr writes rd
// x_commit_valid_i         in   1       commit/kill strobe
// x_commit_id_i            in   ID_W    id being committed
// x_commit_kill_i          in   1       1 = discard, 0 = execute
// x_result_valid_o         out  1       result available
// x_result_ready_i         in   1       core consumes result
// x_result_id_o            out  ID_W    id of result
// x_result_rd_o            out  5       destination register
// x_result_data_o          out  XLEN    result value
// x_result_we_o            out  1       write rd
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge): buffer empty, execute FSM IDLE, all outputs 0 except x_issue_ready_o=1 on the cycle after reset releases.
// - Decode, combinational: opcode 7'b0001011 and funct7=0 -> accept. funct3 selects the op:
//   - 000 add, 001 sub, 010 xor, 011 signed min, 100 signed max, 101 sltu.
//   - Other funct3 values reject. Accept always sets writeback=1; a reject sets accept=0 and writeback=0.
// - Issue handshake at valid & ready.
//   - An accepted handshake pushes {id, rd, funct3, rs1, rs2, committed=0}.
//   - A rejected handshake pushes nothing.
//   - x_issue_ready_o = !full. A full buffer still accepts when the head pops in the same cycle.
// - Commit: x_commit_valid_i searches the valid entries for x_commit_id_i.
//   - Match with kill=0 sets committed.
//   - Match with kill=1 invalidates the entry.
//   - No match is ignored.
//   - Commit of an id issued in the same cycle applies to the new entry.
// - Buffer: circular FIFO with wrapping head/tail pointers.
//   - A killed non-head entry stays as a bubble and is popped without execution when it reaches the head.
// - Execute FSM, in order:
//   - IDLE: if head valid & committed, latch operands, load cnt=LATENCY-1, go to EXEC. If head invalid (killed), pop it and stay in IDLE.
//   - EXEC: decrement cnt. At cnt==0, register the result, pop the head, go to RESP.
//   - RESP: hold x_result_* stable with valid=1. On ready, go to IDLE. Back-to-back results are not required.
// - Min latency from the commit cycle to x_result_valid_o is LATENCY+1 cycles.
// - Arithmetic is XLEN-bit two's complement and wraps. sltu yields a zero-extended 0/1.
// - Kill of the entry in EXEC/RESP has no effect; the result still returns.
// - Reset mid-operation discards all entries and any pending result.
// STRUCTURE
// - Package cvxif_copro_pkg: opcode constant, funct3 enum copro_op_e, entry struct copro_entry_t, fsm enum copro_state_e.
// - One sub-module: cvxif_copro_alu, combinational, takes op/rs1/rs2 and returns result. FIFO and FSM stay in the top.
// TESTING
// - Offer add (funct3=000), id=1, rs1=5, rs2=7; commit id=1 -> accept=1 and writeback=1 at issue; result id=1, data=12, valid exactly 3 cycles after commit.
// - Offer funct3=111 -> accept=0, writeback=0, nothing buffered, no result ever.
// - Issue ids 0..3 with no commits -> ready=0 after 4th; commit id0 and hold ready_i=1 -> ready returns the cycle id0 pops.
// - Issue ids 2,3 (sub 1-2, xor), kill id2, commit id3 -> only id3 result; sub result 0xFFFF_FFFF_FFFF_FFFF never appears.
// - Hold x_result_ready_i=0 for 5 cycles -> id/data/rd stable and valid high throughout; next result waits.
// - Min rs1=-1, rs2=1 -> data=-1; sltu same operands -> data=0; reset asserted in RESP -> valid=0 next cycle, buffer empty.

Source files
------------

// File: rtl/cvxif_copro_pkg.sv
// Shared types and decode helper for the custom-0 CV-X-IF coprocessor responder.
package cvxif_copro_pkg;

   localparam int COPRO_XLEN = 64;
   localparam int COPRO_ID_W = 3;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XOR  = 3'b010,
      OP_MIN  = 3'b011,
      OP_MAX  = 3'b100,
      OP_SLTU = 3'b101
   } copro_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } copro_state_e;

   typedef struct packed {
      logic                  valid;
      logic                  committed;
      logic [COPRO_ID_W-1:0] id;
      logic [4:0]            rd;
      copro_op_e             op;
      logic [COPRO_XLEN-1:0] rs1;
      logic [COPRO_XLEN-1:0] rs2;
   } copro_entry_t;

   // True when the word is a custom-0 instruction with a supported funct3.
   function automatic logic decode_accept(input logic [31:0] instr);
      return (instr[6:0] == OPC_CUSTOM0) && (instr[31:25] == 7'd0) &&
             (instr[14:12] <= 3'd5);
   endfunction

endpackage

// File: rtl/cvxif_copro_alu.sv
// Combinational datapath for the six supported custom-0 operations.
module cvxif_copro_alu
   import cvxif_copro_pkg::*;
#(
   parameter int XLEN = COPRO_XLEN
) (
   input  copro_op_e        op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   output logic [XLEN-1:0]  result
);

   logic lt_s;
   logic lt_u;

   // Operation select; all arithmetic wraps at XLEN bits.
   always_comb begin
      lt_s   = $signed(rs1) < $signed(rs2);
      lt_u   = rs1 < rs2;
      result = '0;
      case (op)
         OP_ADD:  result = rs1 + rs2;
         OP_SUB:  result = rs1 - rs2;
         OP_XOR:  result = rs1 ^ rs2;
         OP_MIN:  result = lt_s ? rs1 : rs2;
         OP_MAX:  result = lt_s ? rs2 : rs1;
         OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/cvxif_copro_responder.sv
// Coprocessor end of CV-X-IF: decode/accept, in-flight buffer, in-order execute.
//
// state  | meaning
// S_IDLE | waiting for a committed head entry; pops killed head bubbles
// S_EXEC | counting down LATENCY cycles on latched operands
// S_RESP | result presented on x_result_*, held until x_result_ready_i
module cvxif_copro_responder
   import cvxif_copro_pkg::*;
#(
   parameter int XLEN    = COPRO_XLEN,
   parameter int ID_W    = COPRO_ID_W,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             x_issue_valid_i,
   output logic             x_issue_ready_o,
   input  logic [31:0]      x_issue_instr_i,
   input  logic [ID_W-1:0]  x_issue_id_i,
   input  logic [XLEN-1:0]  x_issue_rs1_i,
   input  logic [XLEN-1:0]  x_issue_rs2_i,
   output logic             x_issue_accept_o,
   output logic             x_issue_writeback_o,
   input  logic             x_commit_valid_i,
   input  logic [ID_W-1:0]  x_commit_id_i,
   input  logic             x_commit_kill_i,
   output logic             x_result_valid_o,
   input  logic             x_result_ready_i,
   output logic [ID_W-1:0]  x_result_id_o,
   output logic [4:0]       x_result_rd_o,
   output logic [XLEN-1:0]  x_result_data_o,
   output logic             x_result_we_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   copro_entry_t      buf_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [PTR_W:0]    count_q;

   copro_state_e      state_q;
   logic [CNT_W-1:0]  cnt_q;
   copro_op_e         op_q;
   logic [XLEN-1:0]   rs1_q;
   logic [XLEN-1:0]   rs2_q;
   logic [ID_W-1:0]   id_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   alu_res;

   copro_entry_t      head_e;
   logic              head_present;
   logic              full;
   logic              dec_accept;
   logic              push;
   logic              pop;
   logic              new_hit;

   cvxif_copro_alu #(.XLEN(XLEN)) u_alu (
      .op     (op_q),
      .rs1    (rs1_q),
      .rs2    (rs2_q),
      .result (alu_res)
   );

   // Issue decode, handshake and pop qualification.
   always_comb begin
      head_e              = buf_q[head_q];
      head_present        = (count_q != '0);
      full                = (count_q == (PTR_W+1)'(DEPTH));
      dec_accept          = decode_accept(x_issue_instr_i);
      pop                 = ((state_q == S_IDLE) && head_present && !head_e.valid) ||
                            ((state_q == S_EXEC) && (cnt_q == '0));
      x_issue_ready_o     = !full || pop;
      x_issue_accept_o    = x_issue_valid_i && dec_accept;
      x_issue_writeback_o = x_issue_valid_i && dec_accept;
      push                = x_issue_valid_i && x_issue_ready_o && dec_accept;
      new_hit             = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);
   end

   // Circular buffer: commit/kill search, head pop, tail push (push wins on a shared slot).
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (x_commit_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
               // The entry being executed is out of reach of commit/kill.
               if (buf_q[i].valid && (buf_q[i].id == x_commit_id_i) &&
                   !((state_q == S_EXEC) && (PTR_W'(i) == head_q))) begin
                  if (x_commit_kill_i) buf_q[i].valid     <= 1'b0;
                  else                 buf_q[i].committed <= 1'b1;
               end
            end
         end
         if (pop) begin
            buf_q[head_q].valid     <= 1'b0;
            buf_q[head_q].committed <= 1'b0;
            head_q                  <= head_q + 1'b1;
         end
         if (push) begin
            buf_q[tail_q] <= '{valid:     !(new_hit && x_commit_kill_i),
                               committed: new_hit && !x_commit_kill_i,
                               id:        x_issue_id_i,
                               rd:        x_issue_instr_i[11:7],
                               op:        copro_op_e'(x_issue_instr_i[14:12]),
                               rs1:       x_issue_rs1_i,
                               rs2:       x_issue_rs2_i};
            tail_q        <= tail_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Execute FSM with registered result channel.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         op_q             <= OP_ADD;
         rs1_q            <= '0;
         rs2_q            <= '0;
         id_q             <= '0;
         rd_q             <= '0;
         x_result_valid_o <= 1'b0;
         x_result_id_o    <= '0;
         x_result_rd_o    <= '0;
         x_result_data_o  <= '0;
         x_result_we_o    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (head_present && head_e.valid && head_e.committed) begin
                  op_q    <= head_e.op;
                  rs1_q   <= head_e.rs1;
                  rs2_q   <= head_e.rs2;
                  id_q    <= head_e.id;
                  rd_q    <= head_e.rd;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt_q == '0) begin
                  x_result_valid_o <= 1'b1;
                  x_result_id_o    <= id_q;
                  x_result_rd_o    <= rd_q;
                  x_result_data_o  <= alu_res;
                  x_result_we_o    <= 1'b1;
                  state_q          <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (x_result_ready_i) begin
                  x_result_valid_o <= 1'b0;
                  x_result_we_o    <= 1'b0;
                  state_q          <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed and randomized bench for cvxif_copro_responder with an in-order result model.
module tb_cvxif_copro_responder;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        x_issue_valid_i;
   logic        x_issue_ready_o;
   logic [31:0] x_issue_instr_i;
   logic [2:0]  x_issue_id_i;
   logic [63:0] x_issue_rs1_i;
   logic [63:0] x_issue_rs2_i;
   logic        x_issue_accept_o;
   logic        x_issue_writeback_o;
   logic        x_commit_valid_i;
   logic [2:0]  x_commit_id_i;
   logic        x_commit_kill_i;
   logic        x_result_valid_o;
   logic        x_result_ready_i;
   logic [2:0]  x_result_id_o;
   logic [4:0]  x_result_rd_o;
   logic [63:0] x_result_data_o;
   logic        x_result_we_o;

   int checks = 0;
   int errors = 0;

   // Model entry: st 0 = awaiting commit, 1 = committed, 2 = killed.
   typedef struct {
      logic [2:0]  id;
      logic [4:0]  rd;
      logic [63:0] data;
      int          st;
   } ref_t;
   ref_t mq[$];

   cvxif_copro_responder dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .x_issue_valid_i     (x_issue_valid_i),
      .x_issue_ready_o     (x_issue_ready_o),
      .x_issue_instr_i     (x_issue_instr_i),
      .x_issue_id_i        (x_issue_id_i),
      .x_issue_rs1_i       (x_issue_rs1_i),
      .x_issue_rs2_i       (x_issue_rs2_i),
      .x_issue_accept_o    (x_issue_accept_o),
      .x_issue_writeback_o (x_issue_writeback_o),
      .x_commit_valid_i    (x_commit_valid_i),
      .x_commit_id_i       (x_commit_id_i),
      .x_commit_kill_i     (x_commit_kill_i),
      .x_result_valid_o    (x_result_valid_o),
      .x_result_ready_i    (x_result_ready_i),
      .x_result_id_o       (x_result_id_o),
      .x_result_rd_o       (x_result_rd_o),
      .x_result_data_o     (x_result_data_o),
      .x_result_we_o       (x_result_we_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a ^ b;
         3'd3:    return ($signed(a) < $signed(b)) ? a : b;
         3'd4:    return ($signed(a) > $signed(b)) ? a : b;
         3'd5:    return (a < b) ? 64'd1 : 64'd0;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 3))
         0:       return {$urandom, $urandom};
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_0000_0000;
         default: return 64'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic step();
      @(negedge clk_i);
   endtask

   // Offer one instruction at a negedge; returns at the negedge after the handshake.
   task automatic offer(input logic [2:0] id, input logic [6:0] opc, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] b);
      bit exp_acc;
      int budget;
      exp_acc = (opc == 7'b0001011) && (f7 == 7'd0) && (f3 <= 3'd5);
      x_issue_instr_i = {f7, 5'd2, 5'd1, f3, rd, opc};
      x_issue_id_i    = id;
      x_issue_rs1_i   = a;
      x_issue_rs2_i   = b;
      x_issue_valid_i = 1'b1;
      #1;
      chk("issue_accept", 64'(x_issue_accept_o), 64'(exp_acc));
      chk("issue_writeback", 64'(x_issue_writeback_o), 64'(exp_acc));
      budget = 0;
      while (!x_issue_ready_o && budget < 50) begin
         step();
         #1;
         budget++;
      end
      if (budget >= 50) chk("issue_ready_timeout", 64'(x_issue_ready_o), 64'd1);
      step();
      x_issue_valid_i = 1'b0;
      if (exp_acc) mq.push_back('{id: id, rd: rd, data: ref_op(f3, a, b), st: 0});
   endtask

   task automatic commit(input logic [2:0] id, input bit kill);
      x_commit_valid_i = 1'b1;
      x_commit_id_i    = id;
      x_commit_kill_i  = kill;
      step();
      x_commit_valid_i = 1'b0;
      x_commit_kill_i  = 1'b0;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].st == 0 && mq[i].id == id) begin
            mq[i].st = kill ? 2 : 1;
            break;
         end
      end
   endtask

   // Consume results while the oldest live model entry is committed.
   task automatic drain(input bit always_rdy, output int n);
      int budget;
      budget = 0;
      n = 0;
      forever begin
         while (mq.size() > 0 && mq[0].st == 2) void'(mq.pop_front());
         if (mq.size() == 0 || mq[0].st == 0) break;
         if (budget > 300) begin
            chk("drain_timeout", 64'(x_result_valid_o), 64'd1);
            break;
         end
         x_result_ready_i = always_rdy ? 1'b1 : 1'($urandom_range(0, 1));
         if (x_result_valid_o && x_result_ready_i) begin
            chk("result_id", 64'(x_result_id_o), 64'(mq[0].id));
            chk("result_rd", 64'(x_result_rd_o), 64'(mq[0].rd));
            chk("result_data", x_result_data_o, mq[0].data);
            chk("result_we", 64'(x_result_we_o), 64'd1);
            void'(mq.pop_front());
            n++;
         end
         step();
         budget++;
      end
      x_result_ready_i = 1'b0;
   endtask

   task automatic expect_quiet(input int cycles);
      bit seen;
      seen = 1'b0;
      repeat (cycles) begin
         if (x_result_valid_o) seen = 1'b1;
         step();
      end
      chk("no_extra_result", 64'(seen), 64'd0);
      chk("ready_when_empty", 64'(x_issue_ready_o), 64'd1);
   endtask

   task automatic wait_valid(input string tag);
      int budget;
      budget = 0;
      while (!x_result_valid_o && budget < 30) begin
         step();
         budget++;
      end
      chk(tag, 64'(x_result_valid_o), 64'd1);
   endtask

   localparam logic [6:0] OPC = 7'b0001011;

   initial begin
      int n;
      int k;
      logic [2:0] next_id;
      logic [2:0] ids[$];

      rst_ni           = 1'b0;
      x_issue_valid_i  = 1'b0;
      x_issue_instr_i  = '0;
      x_issue_id_i     = '0;
      x_issue_rs1_i    = '0;
      x_issue_rs2_i    = '0;
      x_commit_valid_i = 1'b0;
      x_commit_id_i    = '0;
      x_commit_kill_i  = 1'b0;
      x_result_ready_i = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      step();
      chk("reset_ready", 64'(x_issue_ready_o), 64'd1);
      chk("reset_valid", 64'(x_result_valid_o), 64'd0);
      chk("reset_accept", 64'(x_issue_accept_o), 64'd0);
      chk("reset_we", 64'(x_result_we_o), 64'd0);

      // add 5+7, commit -> valid LATENCY+1 edges after the commit edge
      offer(3'd1, OPC, 7'd0, 3'd0, 5'd3, 64'd5, 64'd7);
      commit(3'd1, 1'b0);
      chk("lat_edge0", 64'(x_result_valid_o), 64'd0);
      step();
      chk("lat_edge1", 64'(x_result_valid_o), 64'd0);
      step();
      chk("lat_edge2", 64'(x_result_valid_o), 64'd0);
      step();
      chk("lat_edge3", 64'(x_result_valid_o), 64'd1);
      chk("add_id", 64'(x_result_id_o), 64'd1);
      chk("add_data", x_result_data_o, 64'd12);
      drain(1'b1, n);
      chk("add_count", 64'(n), 64'd1);

      // reject funct3=111, plus bad opcode and bad funct7
      offer(3'd2, OPC, 7'd0, 3'd7, 5'd4, 64'd1, 64'd1);
      offer(3'd3, 7'b0101011, 7'd0, 3'd0, 5'd4, 64'd1, 64'd1);
      offer(3'd4, OPC, 7'd1, 3'd0, 5'd4, 64'd1, 64'd1);
      commit(3'd2, 1'b0);
      expect_quiet(8);

      // fill buffer with ids 0..3; ready returns in the pop cycle of id0
      for (int i = 0; i < 4; i++) begin
         offer(3'(i), OPC, 7'd0, 3'd0, 5'(i + 8), 64'(i), 64'd100);
         if (i == 2) chk("ready_after_3", 64'(x_issue_ready_o), 64'd1);
      end
      chk("ready_full", 64'(x_issue_ready_o), 64'd0);
      x_result_ready_i = 1'b1;
      commit(3'd0, 1'b0);
      step();
      chk("ready_exec", 64'(x_issue_ready_o), 64'd0);
      step();
      chk("ready_at_pop", 64'(x_issue_ready_o), 64'd1);
      step();
      drain(1'b1, n);
      commit(3'd1, 1'b0);
      commit(3'd2, 1'b0);
      commit(3'd3, 1'b0);
      drain(1'b0, n);
      chk("fill_count", 64'(n), 64'd3);
      expect_quiet(6);

      // kill id2 (sub 1-2), commit id3 (xor)
      offer(3'd2, OPC, 7'd0, 3'd1, 5'd4, 64'd1, 64'd2);
      offer(3'd3, OPC, 7'd0, 3'd2, 5'd5, 64'hF0F0, 64'h0FF0);
      commit(3'd2, 1'b1);
      commit(3'd3, 1'b0);
      wait_valid("kill_wait");
      chk("kill_only_id3", 64'(x_result_id_o), 64'd3);
      chk("kill_xor_data", x_result_data_o, 64'hFF00);
      drain(1'b0, n);
      chk("kill_count", 64'(n), 64'd1);
      expect_quiet(8);

      // backpressure: hold result for 5 cycles
      offer(3'd4, OPC, 7'd0, 3'd0, 5'd6, 64'd10, 64'd20);
      offer(3'd5, OPC, 7'd0, 3'd2, 5'd7, 64'd3, 64'd5);
      commit(3'd4, 1'b0);
      commit(3'd5, 1'b0);
      wait_valid("bp_wait");
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(x_result_valid_o), 64'd1);
         chk("bp_id", 64'(x_result_id_o), 64'd4);
         chk("bp_rd", 64'(x_result_rd_o), 64'd6);
         chk("bp_data", x_result_data_o, 64'd30);
         step();
      end
      x_result_ready_i = 1'b1;
      void'(mq.pop_front());
      step();
      x_result_ready_i = 1'b0;
      chk("bp_next_waits", 64'(x_result_valid_o), 64'd0);
      drain(1'b0, n);
      chk("bp_count", 64'(n), 64'd1);

      // signed min and sltu corner
      offer(3'd6, OPC, 7'd0, 3'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      offer(3'd7, OPC, 7'd0, 3'd5, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      commit(3'd6, 1'b0);
      commit(3'd7, 1'b0);
      wait_valid("min_wait");
      chk("min_data", x_result_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      x_result_ready_i = 1'b1;
      void'(mq.pop_front());
      step();
      x_result_ready_i = 1'b0;
      wait_valid("sltu_wait");
      chk("sltu_data", x_result_data_o, 64'd0);
      drain(1'b0, n);

      // reset while in RESP discards result and buffer
      offer(3'd0, OPC, 7'd0, 3'd0, 5'd1, 64'd1, 64'd1);
      offer(3'd1, OPC, 7'd0, 3'd0, 5'd2, 64'd2, 64'd2);
      commit(3'd0, 1'b0);
      wait_valid("rst_wait");
      rst_ni = 1'b0;
      step();
      chk("rst_valid_drop", 64'(x_result_valid_o), 64'd0);
      rst_ni = 1'b1;
      mq.delete();
      step();
      chk("rst_ready", 64'(x_issue_ready_o), 64'd1);
      commit(3'd1, 1'b0);
      expect_quiet(10);

      // randomized batches against the ordered model
      next_id = 3'd0;
      for (int b = 0; b < 16; b++) begin
         ids.delete();
         k = $urandom_range(1, 4);
         for (int j = 0; j < k; j++) begin
            logic [6:0] opc;
            logic [6:0] f7;
            logic [2:0] f3;
            opc = ($urandom_range(0, 7) == 0) ? 7'b1011011 : OPC;
            f7  = ($urandom_range(0, 7) == 0) ? 7'h20 : 7'd0;
            f3  = 3'($urandom_range(0, 7));
            offer(next_id, opc, f7, f3, 5'($urandom_range(0, 31)), rnd64(), rnd64());
            if (mq.size() > ids.size()) ids.push_back(next_id);
            next_id = next_id + 3'd1;
         end
         for (int i = ids.size() - 1; i > 0; i--) begin
            int j;
            logic [2:0] t;
            j = $urandom_range(0, i);
            t = ids[i];
            ids[i] = ids[j];
            ids[j] = t;
         end
         foreach (ids[i]) commit(ids[i], $urandom_range(0, 3) == 0);
         drain(1'b0, n);
         expect_quiet(6);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
